// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the icache, dcache, write-queue and RAM-side
//                signals around the single-ported memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    // icache read-miss requester
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    // dcache read-miss requester
    logic        dmissREN;
    logic [31:0] dmissaddr;
    logic        dwait;
    // write-queue drain requester
    logic        wq_dqueueWEN;
    logic [31:0] wq_wdaddr;
    logic [31:0] wq_dstore;
    logic        wq_full;
    logic        wq_match;
    logic        wq_dwait;
    // RAM port
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_wait;
    logic [31:0] rdata;

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dmissREN, dmissaddr,
        input  wq_dqueueWEN, wq_wdaddr, wq_dstore, wq_full, wq_match,
        input  ramload, ram_wait,
        output iwait, dwait, wq_dwait,
        output ramREN, ramWEN, ramaddr, ramstore, rdata
    );

    // Requester / memory side
    modport master (
        output iREN, iaddr, dmissREN, dmissaddr,
        output wq_dqueueWEN, wq_wdaddr, wq_dstore, wq_full, wq_match,
        output ramload, ram_wait,
        input  iwait, dwait, wq_dwait,
        input  ramREN, ramWEN, ramaddr, ramstore, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported RAM between icache read misses,
//                dcache read misses and write-queue drains. One single-word
//                transaction at a time, read-after-write ordering on address
//                conflict, forced drain when the queue is full, and bounded
//                icache starvation.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    // Cycles a pending icache request may wait before it outranks dcache.
    parameter int STARVE_LIMIT = 8,
    // Starvation counter width; 2**CNT_W must exceed STARVE_LIMIT.
    parameter int CNT_W        = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IREAD = 2'd1,
        DREAD = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_addr;
    logic [31:0]        r_store;
    logic [31:0]        w_grant_addr;
    logic [31:0]        w_grant_store;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic               w_starved;
    logic               w_done;
    logic               w_raw_conflict;

    // The icache has waited long enough to jump ahead of dcache traffic.
    assign w_starved      = (r_starve_cnt == c_starve_max);
    // A dcache miss whose address still sits in the write queue must wait
    // until every matching entry has been written back.
    assign w_raw_conflict = bus.dmissREN && bus.wq_match && bus.wq_dqueueWEN;
    // Any granted transaction finishes in the first cycle RAM is not busy.
    assign w_done         = (r_state != IDLE) && !bus.ram_wait;

    // Next-state selection: fixed-priority arbitration from IDLE, otherwise
    // hold the granted transaction until RAM releases it.
    always_comb begin
        w_next_state  = r_state;
        w_grant_addr  = r_addr;
        w_grant_store = r_store;
        case (r_state)
            IDLE: begin
                if (bus.wq_dqueueWEN && bus.wq_full) begin
                    w_next_state  = WRITE;
                    w_grant_addr  = bus.wq_wdaddr;
                    w_grant_store = bus.wq_dstore;
                end else if (bus.iREN && w_starved) begin
                    w_next_state  = IREAD;
                    w_grant_addr  = bus.iaddr;
                end else if (w_raw_conflict) begin
                    w_next_state  = WRITE;
                    w_grant_addr  = bus.wq_wdaddr;
                    w_grant_store = bus.wq_dstore;
                end else if (bus.dmissREN) begin
                    w_next_state  = DREAD;
                    w_grant_addr  = bus.dmissaddr;
                end else if (bus.iREN) begin
                    w_next_state  = IREAD;
                    w_grant_addr  = bus.iaddr;
                end else if (bus.wq_dqueueWEN) begin
                    w_next_state  = WRITE;
                    w_grant_addr  = bus.wq_wdaddr;
                    w_grant_store = bus.wq_dstore;
                end
            end
            IREAD, DREAD, WRITE: begin
                if (!bus.ram_wait) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch address/data at the grant edge so the RAM sees stable values for
    // the whole transaction; reads leave the store register untouched.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_addr  <= '0;
            r_store <= '0;
        end else if (r_state == IDLE) begin
            r_addr  <= w_grant_addr;
            r_store <= w_grant_store;
        end
    end

    // Count cycles the icache spends waiting outside its own read; saturate
    // at the limit and restart once its read completes.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_starve_cnt <= '0;
        end else if (r_state == IREAD) begin
            if (!bus.ram_wait) begin
                r_starve_cnt <= '0;
            end
        end else if (bus.iREN && (r_starve_cnt != c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + c_cnt_one;
        end
    end

    // RAM strobes follow the state directly, so they are mutually exclusive
    // and both low in IDLE.
    assign bus.ramREN   = (r_state == IREAD) || (r_state == DREAD);
    assign bus.ramWEN   = (r_state == WRITE);
    assign bus.ramaddr  = r_addr;
    assign bus.ramstore = r_store;
    assign bus.rdata    = bus.ramload;

    // Each wait line drops only during the completing cycle of its own
    // transaction.
    assign bus.iwait    = !(w_done && (r_state == IREAD));
    assign bus.dwait    = !(w_done && (r_state == DREAD));
    assign bus.wq_dwait = !(w_done && (r_state == WRITE));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Randomised and directed bench for mem_port_arbiter with a
//                transaction-level reference model and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int DEPTH        = 4;

    typedef enum logic [1:0] {K_I = 2'd0, K_D = 2'd1, K_W = 2'd2} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wq_ent_t;

    logic clk = 1'b0;
    logic rst_n;

    mem_port_arbiter_if mif ();

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (4)
    ) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (mif)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endfunction

    // RAM contents as the memory holds them, and the "logical" memory that
    // already includes every write still sitting in the queue.
    logic [31:0] ram_mem [0:1023];
    logic [31:0] lmem    [0:1023];
    assign mif.ramload = ram_mem[mif.ramaddr[9:0]];

    wq_ent_t     wq[$];
    logic [31:0] d_exp;        // data the pending dcache read must return
    txn_t        exp_q[$];     // expected transactions, oldest first
    txn_t        done_log[$];  // observed completions
    int          i_while_d;

    // ------------------------------------------------------------------
    // Reference model: at each edge an idle port grants by priority rule;
    // a busy port finishes when RAM is not busy.
    // ------------------------------------------------------------------
    bit    m_busy = 1'b0;
    kind_t m_kind = K_I;
    int    m_cnt  = 0;

    always @(posedge clk) begin
        bit   in_iread;
        bit   grant;
        txn_t t;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            exp_q.delete();
        end else begin
            in_iread = m_busy && (m_kind == K_I);
            if (m_busy) begin
                if (!mif.ram_wait) m_busy = 1'b0;
            end else begin
                grant  = 1'b1;
                t.data = 32'h0;
                if (mif.wq_dqueueWEN && mif.wq_full) begin
                    t.kind = K_W; t.addr = mif.wq_wdaddr; t.data = mif.wq_dstore;
                end else if (mif.iREN && m_cnt == STARVE_LIMIT) begin
                    t.kind = K_I; t.addr = mif.iaddr;
                end else if (mif.dmissREN && mif.wq_match && mif.wq_dqueueWEN) begin
                    t.kind = K_W; t.addr = mif.wq_wdaddr; t.data = mif.wq_dstore;
                end else if (mif.dmissREN) begin
                    t.kind = K_D; t.addr = mif.dmissaddr; t.data = d_exp;
                end else if (mif.iREN) begin
                    t.kind = K_I; t.addr = mif.iaddr;
                end else if (mif.wq_dqueueWEN) begin
                    t.kind = K_W; t.addr = mif.wq_wdaddr; t.data = mif.wq_dstore;
                end else begin
                    grant = 1'b0;
                end
                if (grant) begin
                    m_busy = 1'b1;
                    m_kind = t.kind;
                    exp_q.push_back(t);
                end
            end
            if (in_iread) begin
                if (!mif.ram_wait) m_cnt = 0;
            end else if (mif.iREN && m_cnt < STARVE_LIMIT) begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares the DUT against the oldest expected transaction.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        txn_t t;
        txn_t obs;
        if (exp_q.size() == 0) begin
            check("idle_strobes", {30'h0, mif.ramREN, mif.ramWEN}, 32'h0);
            check("idle_waits", {29'h0, mif.iwait, mif.dwait, mif.wq_dwait}, 32'h7);
        end else begin
            t = exp_q[0];
            check("strobes", {30'h0, mif.ramREN, mif.ramWEN}, (t.kind == K_W) ? 32'h1 : 32'h2);
            check("ramaddr", mif.ramaddr, t.addr);
            if (t.kind == K_W) check("ramstore", mif.ramstore, t.data);
            if (!mif.ram_wait) begin
                check("done_waits", {29'h0, mif.iwait, mif.dwait, mif.wq_dwait},
                      (t.kind == K_I) ? 32'h3 : (t.kind == K_D) ? 32'h5 : 32'h6);
                if (t.kind == K_D) check("d_rdata", mif.rdata, t.data);
                if (t.kind == K_I) check("i_rdata", mif.rdata, ram_mem[t.addr[9:0]]);
                obs.kind = t.kind;
                obs.addr = mif.ramaddr;
                obs.data = (t.kind == K_W) ? mif.ramstore : mif.rdata;
                done_log.push_back(obs);
                void'(exp_q.pop_front());
            end else begin
                check("busy_waits", {29'h0, mif.iwait, mif.dwait, mif.wq_dwait}, 32'h7);
            end
        end
    end

    // ------------------------------------------------------------------
    // Requester agents
    // ------------------------------------------------------------------
    int pi = 0, pd = 0, pw = 0, prw = -1;
    logic       s_ren, s_wen, s_iwait, s_dwait;
    logic [31:0] s_addr, s_store;

    task automatic update_wq();
        logic m;
        m = 1'b0;
        foreach (wq[k]) if (wq[k].addr == mif.dmissaddr) m = 1'b1;
        mif.wq_dqueueWEN = (wq.size() > 0);
        mif.wq_wdaddr    = (wq.size() > 0) ? wq[0].addr : 32'h0;
        mif.wq_dstore    = (wq.size() > 0) ? wq[0].data : 32'h0;
        mif.wq_full      = (wq.size() == DEPTH);
        mif.wq_match     = m;
    endtask

    task automatic issue_i(input logic [31:0] a);
        mif.iREN  = 1'b1;
        mif.iaddr = a;
    endtask

    task automatic issue_d(input logic [31:0] a);
        mif.dmissREN  = 1'b1;
        mif.dmissaddr = a;
        d_exp         = lmem[a[9:0]];
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        wq_ent_t e;
        if (wq.size() < DEPTH && !(mif.dmissREN && a == mif.dmissaddr)) begin
            e.addr = a;
            e.data = d;
            wq.push_back(e);
            lmem[a[9:0]] = d;
        end
    endtask

    // One clock cycle: sample at the falling edge, react after the rising edge.
    task automatic step();
        bit          idn, ddn, wdn, wr;
        logic [31:0] wa, wd;
        @(negedge clk);
        idn = !mif.iwait; ddn = !mif.dwait; wdn = !mif.wq_dwait;
        wr  = mif.ramWEN && !mif.ram_wait;
        wa  = mif.ramaddr; wd = mif.ramstore;
        s_ren = mif.ramREN; s_wen = mif.ramWEN; s_addr = mif.ramaddr;
        s_store = mif.ramstore; s_iwait = mif.iwait; s_dwait = mif.dwait;
        if (idn && mif.dmissREN) i_while_d++;
        @(posedge clk);
        #1;
        if (wr) ram_mem[wa[9:0]] = wd;
        if (wdn && wq.size() > 0) void'(wq.pop_front());
        if (idn) mif.iREN = 1'b0;
        if (ddn) mif.dmissREN = 1'b0;
        if (!mif.iREN && int'($urandom_range(99)) < pi) issue_i(32'($urandom_range(15)));
        if (!mif.dmissREN && int'($urandom_range(99)) < pd) issue_d(32'($urandom_range(15)));
        if (int'($urandom_range(99)) < pw) push_w(32'($urandom_range(15)), $urandom);
        if (prw >= 0) mif.ram_wait = (int'($urandom_range(99)) < prw);
        update_wq();
    endtask

    task automatic run_until_quiet(input int max_cycles);
        bit quiet;
        quiet = 1'b0;
        for (int n = 0; n < max_cycles && !quiet; n++) begin
            step();
            quiet = !mif.iREN && !mif.dmissREN && (wq.size() == 0) && (exp_q.size() == 0);
        end
        check("quiet_timeout", {31'h0, !quiet}, 32'h0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        for (int k = 0; k < 1024; k++) begin
            ram_mem[k] = 32'(k * 7 + 3);
            lmem[k]    = 32'(k * 7 + 3);
        end
        rst_n = 1'b0;
        mif.iREN = 1'b0; mif.iaddr = '0;
        mif.dmissREN = 1'b0; mif.dmissaddr = '0;
        mif.ram_wait = 1'b0;
        d_exp = '0;
        i_while_d = 0;
        update_wq();

        // Reset then idle
        step(); step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("rst_idle", {s_ren, s_wen, s_iwait, s_dwait, s_addr[27:0]}, 32'h3000_0000);
            check("rst_store", s_store, 32'h0);
        end

        // Single icache read with three busy cycles
        done_log.delete();
        mif.ram_wait = 1'b1;
        issue_i(32'h100);
        for (int c = 0; c <= 5; c++) begin
            step();
            check("i_lat_iwait", {31'h0, s_iwait}, (c == 4) ? 32'h0 : 32'h1);
            check("i_lat_ren", {31'h0, s_ren}, (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
            mif.ram_wait = (c + 1 >= 4) ? 1'b0 : 1'b1;
        end
        check("i_single_n", done_log.size(), 1);

        // Simultaneous requests: dcache, icache, then drain
        done_log.delete();
        mif.ram_wait = 1'b0;
        issue_i(32'h104);
        issue_d(32'h200);
        push_w(32'h300, 32'hCAFE_0300);
        update_wq();
        run_until_quiet(40);
        check("sim_n", done_log.size(), 3);
        if (done_log.size() == 3) begin
            check("sim_0", {30'h0, done_log[0].kind}, {30'h0, K_D});
            check("sim_0a", done_log[0].addr, 32'h200);
            check("sim_1", {30'h0, done_log[1].kind}, {30'h0, K_I});
            check("sim_2", {30'h0, done_log[2].kind}, {30'h0, K_W});
            check("sim_2d", done_log[2].data, 32'hCAFE_0300);
        end

        // Read-after-write conflict
        done_log.delete();
        push_w(32'h40, 32'hDEAD);
        issue_d(32'h40);
        update_wq();
        run_until_quiet(40);
        check("raw_n", done_log.size(), 2);
        if (done_log.size() == 2) begin
            check("raw_0", {30'h0, done_log[0].kind}, {30'h0, K_W});
            check("raw_1", {30'h0, done_log[1].kind}, {30'h0, K_D});
            check("raw_1d", done_log[1].data, 32'hDEAD);
        end

        // Full queue outranks everything
        done_log.delete();
        for (int k = 0; k < DEPTH; k++) push_w(32'(16 + k), 32'(32'hF000 + k));
        issue_i(32'h20);
        issue_d(32'h30);
        update_wq();
        run_until_quiet(60);
        check("full_n", done_log.size(), DEPTH + 2);
        if (done_log.size() > 0) begin
            check("full_0", {30'h0, done_log[0].kind}, {30'h0, K_W});
            check("full_0a", done_log[0].addr, 32'h10);
        end

        // Starvation: dcache requests back to back, icache held
        i_while_d = 0;
        pi = 100; pd = 100; pw = 0;
        mif.ram_wait = 1'b0;
        for (int c = 0; c < 60; c++) step();
        pi = 0; pd = 0;
        run_until_quiet(40);
        check("starve_served", {31'h0, (i_while_d >= 3)}, 32'h1);

        // Reset in the middle of a dcache read
        mif.ram_wait = 1'b1;
        issue_d(32'h55);
        update_wq();
        step();
        step();
        check("mid_ren", {31'h0, s_ren}, 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mif.dmissREN = 1'b0;
        update_wq();
        step();
        check("mid_rst_ren", {31'h0, s_ren}, 32'h0);
        check("mid_rst_dwait", {31'h0, s_dwait}, 32'h1);
        check("mid_rst_addr", s_addr, 32'h0);
        mif.ram_wait = 1'b0;
        step(); step();

        // Randomised traffic
        pi = 30; pd = 30; pw = 40; prw = 30;
        for (int c = 0; c < 3000; c++) step();
        pi = 0; pd = 0; pw = 0; prw = -1;
        mif.ram_wait = 1'b0;
        run_until_quiet(300);
        check("exp_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
